fpu_div_exp_ctl: RTL

// - Sequencer for the divide-pipe exponent datapath: tracks one fdiv from d1stg_step through d7.
// - Drives every exponent-adder select line, register load enable and stage strobe; counts quotient iterations.
// - Sits in the divide pipe beside the mantissa control; accepts one op at a time.

---
 rtl/fpu_div_pkg.sv | 35 +++
 rtl/fpu_div_iter_cnt.sv | 34 +++
 rtl/fpu_div_exp_ctl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_div_pkg.sv
// Shared definitions for the divide-pipe exponent sequencer: state codes,
// special-result codes and default iteration counts.
package fpu_div_pkg;

  // Quotient iteration cycle counts for each precision
  localparam int ITER_DBL_DEF = 55;
  localparam int ITER_SNG_DEF = 26;
  localparam int CNT_W_DEF    = 6;

  // Sequencer state encoding (plain constants for legacy tool compatibility)
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_D2   = 4'd1;
  localparam state_t ST_D3A  = 4'd2;
  localparam state_t ST_D3   = 4'd3;
  localparam state_t ST_D4   = 4'd4;
  localparam state_t ST_ITER = 4'd5;
  localparam state_t ST_D5   = 4'd6;
  localparam state_t ST_D6   = 4'd7;
  localparam state_t ST_D7   = 4'd8;

  // Special-result codes carried with the op into D4
  typedef enum logic [1:0] {
    SPEC_NORM = 2'b00,
    SPEC_ZERO = 2'b01,
    SPEC_C835 = 2'b10,
    SPEC_C118 = 2'b11
  } spec_t;

  // A new op can be accepted while idle or while the previous op finishes
  function automatic logic state_ready(input state_t st);
    return (st == ST_IDLE) || (st == ST_D7);
  endfunction

endpackage

// File: rtl/fpu_div_iter_cnt.sv
// Loadable down-counter with zero flag, used to time quotient iterations.
// Clear outranks load, load outranks decrement; decrement holds at zero.
module fpu_div_iter_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  // Counter register: clear / load / saturating decrement
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/fpu_div_exp_ctl.sv
// Exponent-datapath sequencer for the divide pipe. Tracks one fdiv from
// acceptance through D7 and decodes every exponent select, load enable and
// stage strobe from registered state only.
// Optional macro FPU_DIV_EXP_CTL_FLUSH_EN adds the div_flush input, which
// aborts the op in flight and returns to IDLE on the next edge.
module fpu_div_exp_ctl
  import fpu_div_pkg::*;
#(
  parameter int ITER_DBL = ITER_DBL_DEF,
  parameter int ITER_SNG = ITER_SNG_DEF,
  parameter int CNT_W    = CNT_W_DEF    // 2**CNT_W must exceed both iteration counts
) (
  input  logic       rclk,
  input  logic       arst_l,
  input  logic       d1stg_step,
  input  logic       d1stg_dbl,
  input  logic [1:0] d1stg_spec,
`ifdef FPU_DIV_EXP_CTL_FLUSH_EN
  input  logic       div_flush,
`endif
  output logic       div_ready,
  output logic       d234stg_fdiv,
  output logic       div_expadd1_in1_dbl,
  output logic       div_expadd1_in1_sng,
  output logic       div_expadd1_in2_exp_in2_dbl,
  output logic       div_expadd1_in2_exp_in2_sng,
  output logic       d3stg_fdiv,
  output logic       d4stg_fdiv,
  output logic       div_exp1_expadd1,
  output logic       div_exp1_0835,
  output logic       div_exp1_0118,
  output logic       div_exp1_zero,
  output logic       div_exp1_load,
  output logic       d5stg_fdiva,
  output logic       d5stg_fdivd,
  output logic       d5stg_fdivs,
  output logic       d6stg_fdiv,
  output logic       d7stg_fdiv,
  output logic       d7stg_fdivd,
  output logic       div_expadd2_in1_exp_out,
  output logic       div_exp_out_expadd2,
  output logic       div_exp_out_exp_out,
  output logic       div_exp_out_load,
  output logic       div_done
);

  // Counter start values: the op leaves ITER in the cycle the count hits 0,
  // so loading N-1 yields exactly N iteration cycles.
  localparam logic [CNT_W-1:0] LOAD_DBL = CNT_W'(ITER_DBL - 1);
  localparam logic [CNT_W-1:0] LOAD_SNG = CNT_W'(ITER_SNG - 1);

  state_t     state_reg, state_next;
  logic       dbl_reg;
  logic [1:0] spec_reg;
  logic       flush;
  logic       accept;
  logic       cnt_zero;
  logic [CNT_W-1:0] cnt_val;

`ifdef FPU_DIV_EXP_CTL_FLUSH_EN
  assign flush = div_flush;
`else
  assign flush = 1'b0;
`endif

  // A step is taken only when ready and not being flushed on the same edge
  assign accept = d1stg_step && state_ready(state_reg) && !flush;

  fpu_div_iter_cnt #(
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .rclk     (rclk),
    .arst_l   (arst_l),
    .clr      (flush),
    .load     (state_reg == ST_D4),
    .load_val (dbl_reg ? LOAD_DBL : LOAD_SNG),
    .dec      (state_reg == ST_ITER),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  // Next-state logic; flush forces IDLE from any state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_D2;
      ST_D2:   state_next = ST_D3A;
      ST_D3A:  state_next = ST_D3;
      ST_D3:   state_next = ST_D4;
      ST_D4:   state_next = ST_ITER;
      ST_ITER: if (cnt_zero) state_next = ST_D5;
      ST_D5:   state_next = ST_D6;
      ST_D6:   state_next = ST_D7;
      ST_D7:   state_next = accept ? ST_D2 : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // State register plus op attributes latched on acceptance
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_reg <= ST_IDLE;
      dbl_reg   <= 1'b0;
      spec_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        dbl_reg  <= d1stg_dbl;
        spec_reg <= d1stg_spec;
      end
    end
  end

  // Output decode from registered state and latched attributes only
  always_comb begin
    div_ready                   = state_ready(state_reg);
    d234stg_fdiv                = 1'b0;
    div_expadd1_in1_dbl         = 1'b0;
    div_expadd1_in1_sng         = 1'b0;
    div_expadd1_in2_exp_in2_dbl = 1'b0;
    div_expadd1_in2_exp_in2_sng = 1'b0;
    d3stg_fdiv                  = 1'b0;
    d4stg_fdiv                  = 1'b0;
    div_exp1_expadd1            = 1'b0;
    div_exp1_0835               = 1'b0;
    div_exp1_0118               = 1'b0;
    div_exp1_zero               = 1'b0;
    div_exp1_load               = 1'b0;
    d5stg_fdiva                 = 1'b0;
    d5stg_fdivd                 = 1'b0;
    d5stg_fdivs                 = 1'b0;
    d6stg_fdiv                  = 1'b0;
    d7stg_fdiv                  = 1'b0;
    d7stg_fdivd                 = 1'b0;
    div_expadd2_in1_exp_out     = 1'b0;
    div_exp_out_expadd2         = 1'b0;
    div_exp_out_exp_out         = 1'b0;
    div_exp_out_load            = 1'b0;
    div_done                    = 1'b0;
    case (state_reg)
      ST_D2: begin
        div_expadd1_in1_dbl = dbl_reg;
        div_expadd1_in1_sng = !dbl_reg;
        div_exp1_expadd1    = 1'b1;
        div_exp1_load       = 1'b1;
      end
      ST_D3A: begin
        d234stg_fdiv                = 1'b1;
        div_expadd1_in2_exp_in2_dbl = dbl_reg;
        div_expadd1_in2_exp_in2_sng = !dbl_reg;
        div_exp1_expadd1            = 1'b1;
        div_exp1_load               = 1'b1;
      end
      ST_D3: begin
        d234stg_fdiv     = 1'b1;
        d3stg_fdiv       = 1'b1;
        div_exp1_expadd1 = 1'b1;
        div_exp1_load    = 1'b1;
      end
      ST_D4: begin
        d234stg_fdiv     = 1'b1;
        d4stg_fdiv       = 1'b1;
        div_exp1_load    = 1'b1;
        div_exp1_expadd1 = (spec_reg == SPEC_NORM);
        div_exp1_zero    = (spec_reg == SPEC_ZERO);
        div_exp1_0835    = (spec_reg == SPEC_C835);
        div_exp1_0118    = (spec_reg == SPEC_C118);
      end
      ST_D5: begin
        d5stg_fdiva         = 1'b1;
        d5stg_fdivd         = dbl_reg;
        d5stg_fdivs         = !dbl_reg;
        div_exp_out_expadd2 = 1'b1;
        div_exp_out_load    = 1'b1;
      end
      ST_D6: begin
        d6stg_fdiv              = 1'b1;
        div_expadd2_in1_exp_out = 1'b1;
        div_exp_out_expadd2     = 1'b1;
        div_exp_out_load        = 1'b1;
      end
      ST_D7: begin
        d7stg_fdiv              = 1'b1;
        d7stg_fdivd             = dbl_reg;
        div_expadd2_in1_exp_out = 1'b1;
        div_exp_out_exp_out     = 1'b1;
        div_exp_out_load        = 1'b1;
        div_done                = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
